// File: rtl/tiny_rv_pkg.sv
// Shared tiny_rv definitions: decode opcodes and hazard sequencer states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tiny_rv_pkg;

   // RV32I major opcodes that the hazard logic needs to recognise
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;

   typedef enum logic [1:0] {
      S_RUN   = 2'd0,
      S_LU    = 2'd1,
      S_MEM   = 2'd2,
      S_FLUSH = 2'd3
   } hazard_state_e;

endpackage

// File: rtl/tiny_rv_hazard_detect.sv
// Load-use detector: does the decode instruction read the register an EX load writes.
// Latency: purely combinational.
// Backpressure: none; the sequencer decides whether the result is acted on.
module tiny_rv_hazard_detect
   import tiny_rv_pkg::*;
(
   input  logic [6:0] i_opcode,
   input  logic [4:0] i_rs1,
   input  logic [4:0] i_rs2,
   input  logic       i_ex_is_load,
   input  logic [4:0] i_ex_rd,
   output logic       o_hazard
);

   logic w_uses_rs1;
   logic w_uses_rs2;
   logic w_rs1_match;
   logic w_rs2_match;

   // U-type and JAL carry immediate bits in the rs1 field; only R/B/S formats read rs2
   always_comb begin
      w_uses_rs1 = 1'b1;
      w_uses_rs2 = 1'b0;
      case (i_opcode)
         OPC_LUI, OPC_AUIPC, OPC_JAL:   w_uses_rs1 = 1'b0;
         OPC_OP, OPC_BRANCH, OPC_STORE: w_uses_rs2 = 1'b1;
         default: ;
      endcase
   end

   assign w_rs1_match = w_uses_rs1 && (i_rs1 == i_ex_rd);
   assign w_rs2_match = w_uses_rs2 && (i_rs2 == i_ex_rd);
   // x0 is never a real dependency
   assign o_hazard    = i_ex_is_load && (i_ex_rd != 5'd0) && (w_rs1_match || w_rs2_match);

endmodule

// File: rtl/tiny_rv_hazard_ctrl.sv
// Pipeline sequencer: stall/flush/bubble/redirect from load-use, mem wait, taken branch.
// Latency: outputs combinational from state+inputs; state and flush counter registered.
// Backpressure: mem wait dominates (stall, redirect held off); optional TINY_RV_HAZARD_PERF_EN adds counters.
module tiny_rv_hazard_ctrl
   import tiny_rv_pkg::*;
#(
   parameter int FLUSH_CYCLES = 2,
   parameter int PC_W         = 32
)
(
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic [6:0]      decode_opcode,
   input  logic [4:0]      decode_rs1,
   input  logic [4:0]      decode_rs2,
   input  logic            ex_is_load,
   input  logic [4:0]      ex_rd,
   input  logic            ex_redirect,
   input  logic [PC_W-1:0] ex_target,
   input  logic            mem_req,
   input  logic            mem_ready,
   output logic            o_pipe_stall,
   output logic            o_pipe_flush,
   output logic            o_ex_bubble,
   output logic            o_redirect_valid,
   output logic [PC_W-1:0] o_redirect_pc
`ifdef TINY_RV_HAZARD_PERF_EN
   ,
   output logic [31:0]     o_stall_cycles,
   output logic [31:0]     o_flush_events
`endif
);

   localparam logic [2:0] LP_FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

   hazard_state_e r_state;
   hazard_state_e w_next_state;
   logic [2:0]    r_flush_cnt;
   logic [2:0]    w_next_cnt;
   logic          w_mem_wait;
   logic          w_lu_hazard;
   logic          w_stall;
   logic          w_flush;
   logic          w_bubble;
   logic          w_redir;

   assign w_mem_wait = mem_req && !mem_ready;

   tiny_rv_hazard_detect u_detect (
      .i_opcode     (decode_opcode),
      .i_rs1        (decode_rs1),
      .i_rs2        (decode_rs2),
      .i_ex_is_load (ex_is_load),
      .i_ex_rd      (ex_rd),
      .o_hazard     (w_lu_hazard)
   );

   // Priority arbitration: mem wait > redirect > load-use, per current state
   always_comb begin
      w_next_state = r_state;
      w_next_cnt   = r_flush_cnt;
      w_stall      = 1'b0;
      w_flush      = 1'b0;
      w_bubble     = 1'b0;
      w_redir      = 1'b0;
      case (r_state)
         S_RUN, S_LU: begin
            if (w_mem_wait) begin
               w_stall      = 1'b1;
               w_next_state = S_MEM;
            end else if (ex_redirect) begin
               w_redir  = 1'b1;
               w_flush  = 1'b1;
               w_bubble = 1'b1;
               if (FLUSH_CYCLES > 1) begin
                  w_next_state = S_FLUSH;
                  w_next_cnt   = LP_FLUSH_RELOAD;
               end else begin
                  w_next_state = S_RUN;
               end
            end else if ((r_state == S_RUN) && w_lu_hazard) begin
               w_stall      = 1'b1;
               w_bubble     = 1'b1;
               w_next_state = S_LU;
            end else begin
               w_next_state = S_RUN;
            end
         end
         S_MEM: begin
            if (w_mem_wait) begin
               w_stall = 1'b1;
            end else begin
               // a non-zero count means the wait interrupted a flush window
               w_next_state = (r_flush_cnt != 3'd0) ? S_FLUSH : S_RUN;
            end
         end
         S_FLUSH: begin
            // EX holds only bubbles here, so ex_redirect is not looked at
            w_flush = 1'b1;
            if (w_mem_wait) begin
               w_stall      = 1'b1;
               w_next_state = S_MEM;
            end else begin
               w_bubble   = 1'b1;
               w_next_cnt = (r_flush_cnt != 3'd0) ? (r_flush_cnt - 3'd1) : 3'd0;
               if (r_flush_cnt <= 3'd1) begin
                  w_next_state = S_RUN;
               end
            end
         end
         default: begin
            w_next_state = S_RUN;
            w_next_cnt   = 3'd0;
         end
      endcase
   end

   // Outputs are forced low during the reset cycle
   assign o_pipe_stall     = w_stall  && !i_reset;
   assign o_pipe_flush     = w_flush  && !i_reset;
   assign o_ex_bubble      = w_bubble && !i_reset;
   assign o_redirect_valid = w_redir  && !i_reset;
   assign o_redirect_pc    = o_redirect_valid ? ex_target : '0;

   // State and flush counter registers
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state     <= S_RUN;
         r_flush_cnt <= 3'd0;
      end else begin
         r_state     <= w_next_state;
         r_flush_cnt <= w_next_cnt;
      end
   end

`ifdef TINY_RV_HAZARD_PERF_EN
   logic [31:0] r_stall_cycles;
   logic [31:0] r_flush_events;

   // Free-running event counters, wrap naturally at 2^32
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_stall_cycles <= 32'd0;
         r_flush_events <= 32'd0;
      end else begin
         if (o_pipe_stall)     r_stall_cycles <= r_stall_cycles + 32'd1;
         if (o_redirect_valid) r_flush_events <= r_flush_events + 32'd1;
      end
   end

   assign o_stall_cycles = r_stall_cycles;
   assign o_flush_events = r_flush_events;
`endif

endmodule

// File: tb/tb_tiny_rv_hazard_ctrl.sv
// Directed bench for tiny_rv_hazard_ctrl (FLUSH_CYCLES = 2).
// Each table row is one clock: inputs driven after the edge, outputs sampled on the falling edge.
// Expected flag nibble is {stall, flush, bubble, redirect_valid}.
module tb_tiny_rv_hazard_ctrl;

   localparam logic [6:0] T_OP     = 7'b0110011;
   localparam logic [6:0] T_STORE  = 7'b0100011;
   localparam logic [6:0] T_BRANCH = 7'b1100011;
   localparam logic [6:0] T_LOAD   = 7'b0000011;
   localparam logic [6:0] T_LUI    = 7'b0110111;

   logic        clk = 1'b0;
   logic        rst;
   logic [6:0]  decode_opcode;
   logic [4:0]  decode_rs1;
   logic [4:0]  decode_rs2;
   logic        ex_is_load;
   logic [4:0]  ex_rd;
   logic        ex_redirect;
   logic [31:0] ex_target;
   logic        mem_req;
   logic        mem_ready;
   logic        o_pipe_stall;
   logic        o_pipe_flush;
   logic        o_ex_bubble;
   logic        o_redirect_valid;
   logic [31:0] o_redirect_pc;
`ifdef TINY_RV_HAZARD_PERF_EN
   logic [31:0] o_stall_cycles;
   logic [31:0] o_flush_events;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic        rst;
      logic [6:0]  op;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic        ld;
      logic [4:0]  rd;
      logic        redir;
      logic [31:0] tgt;
      logic        req;
      logic        rdy;
      logic [3:0]  exp;
      string       name;
   } vec_t;

   vec_t tbl[$];

   tiny_rv_hazard_ctrl #(.FLUSH_CYCLES(2), .PC_W(32)) dut (
      .i_clk            (clk),
      .i_reset          (rst),
      .decode_opcode    (decode_opcode),
      .decode_rs1       (decode_rs1),
      .decode_rs2       (decode_rs2),
      .ex_is_load       (ex_is_load),
      .ex_rd            (ex_rd),
      .ex_redirect      (ex_redirect),
      .ex_target        (ex_target),
      .mem_req          (mem_req),
      .mem_ready        (mem_ready),
      .o_pipe_stall     (o_pipe_stall),
      .o_pipe_flush     (o_pipe_flush),
      .o_ex_bubble      (o_ex_bubble),
      .o_redirect_valid (o_redirect_valid),
      .o_redirect_pc    (o_redirect_pc)
`ifdef TINY_RV_HAZARD_PERF_EN
      ,
      .o_stall_cycles   (o_stall_cycles),
      .o_flush_events   (o_flush_events)
`endif
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic r, input logic [6:0] op, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic ld, input logic [4:0] rd,
                               input logic redir, input logic [31:0] tgt, input logic req,
                               input logic rdy, input logic [3:0] exp, input string name);
      vec_t v;
      v.rst = r; v.op = op; v.rs1 = rs1; v.rs2 = rs2; v.ld = ld; v.rd = rd;
      v.redir = redir; v.tgt = tgt; v.req = req; v.rdy = rdy; v.exp = exp; v.name = name;
      return v;
   endfunction

   task automatic drive(input vec_t v);
      rst           = v.rst;
      decode_opcode = v.op;
      decode_rs1    = v.rs1;
      decode_rs2    = v.rs2;
      ex_is_load    = v.ld;
      ex_rd         = v.rd;
      ex_redirect   = v.redir;
      ex_target     = v.tgt;
      mem_req       = v.req;
      mem_ready     = v.rdy;
   endtask

   task automatic check(input string nm, input logic [3:0] exp, input logic [31:0] exp_pc);
      logic [3:0] got;
      got = {o_pipe_stall, o_pipe_flush, o_ex_bubble, o_redirect_valid};
      n_cmp++;
      if (got !== exp || (exp[0] && o_redirect_pc !== exp_pc)) begin
         n_bad++;
         $display("FAIL %s: got {stall,flush,bubble,rv}=%b pc=%h, expected %b pc=%h",
                  nm, got, o_redirect_pc, exp, exp_pc);
      end
   endtask

   task automatic step(input vec_t v);
      @(posedge clk);
      #1;
      drive(v);
      @(negedge clk);
      check(v.name, v.exp, v.tgt);
   endtask

   initial begin
      int exp_stalls;
      int exp_redirs;
      vec_t v;

      // reset cycle with live hazard and redirect inputs: outputs must stay low
      tbl.push_back(mk(1, T_OP,    5, 7, 1, 5, 1, 32'h100, 0, 0, 4'b0000, "reset_cycle"));
      tbl.push_back(mk(0, T_OP,    0, 0, 0, 0, 0, 32'h0,   0, 0, 4'b0000, "idle"));
      // ADD x6,x5,x7 behind LW x5
      tbl.push_back(mk(0, T_OP,    5, 7, 1, 5, 0, 32'h0,   0, 0, 4'b1010, "lu_add_rs1"));
      tbl.push_back(mk(0, T_OP,    5, 7, 1, 5, 0, 32'h0,   0, 0, 4'b0000, "lu_no_second"));
      tbl.push_back(mk(0, T_OP,    0, 0, 0, 0, 0, 32'h0,   0, 0, 4'b0000, "idle2"));
      tbl.push_back(mk(0, T_OP,    0, 0, 1, 0, 0, 32'h0,   0, 0, 4'b0000, "lu_rd_x0"));
      tbl.push_back(mk(0, T_LUI,   5, 5, 1, 5, 0, 32'h0,   0, 0, 4'b0000, "lu_lui"));
      tbl.push_back(mk(0, T_STORE, 1, 5, 1, 5, 0, 32'h0,   0, 0, 4'b1010, "lu_sw_rs2"));
      tbl.push_back(mk(0, T_OP,    0, 0, 0, 0, 0, 32'h0,   0, 0, 4'b0000, "after_sw"));
      tbl.push_back(mk(0, T_LOAD,  3, 5, 1, 5, 0, 32'h0,   0, 0, 4'b0000, "lu_load_no_rs2"));
      tbl.push_back(mk(0, T_BRANCH,2, 5, 1, 5, 0, 32'h0,   0, 0, 4'b1010, "lu_branch_rs2"));
      // redirect arriving while in S_LU
      tbl.push_back(mk(0, T_OP,    0, 0, 0, 0, 1, 32'h200, 0, 0, 4'b0111, "redir_in_lu"));
      tbl.push_back(mk(0, T_OP,    0, 0, 0, 0, 0, 32'h0,   0, 0, 4'b0110, "flush_after_lu"));
      tbl.push_back(mk(0, T_OP,    0, 0, 0, 0, 0, 32'h0,   0, 0, 4'b0000, "idle3"));
      // basic redirect: flush held exactly two cycles, redirect ignored in flush
      tbl.push_back(mk(0, T_OP,    0, 0, 0, 0, 1, 32'h100, 0, 0, 4'b0111, "redir_0x100"));
      tbl.push_back(mk(0, T_OP,    0, 0, 0, 0, 1, 32'h300, 0, 0, 4'b0110, "flush_ignores_redir"));
      tbl.push_back(mk(0, T_OP,    0, 0, 0, 0, 0, 32'h0,   0, 0, 4'b0000, "flush_done"));
      // three wait cycles with a branch pending, then re-presented after ready
      tbl.push_back(mk(0, T_OP,    0, 0, 0, 0, 1, 32'h400, 1, 0, 4'b1000, "memwait1"));
      tbl.push_back(mk(0, T_OP,    0, 0, 0, 0, 1, 32'h400, 1, 0, 4'b1000, "memwait2"));
      tbl.push_back(mk(0, T_OP,    0, 0, 0, 0, 1, 32'h400, 1, 0, 4'b1000, "memwait3"));
      tbl.push_back(mk(0, T_OP,    0, 0, 0, 0, 1, 32'h400, 1, 1, 4'b0000, "mem_ready"));
      tbl.push_back(mk(0, T_OP,    0, 0, 0, 0, 1, 32'h400, 0, 0, 4'b0111, "redir_after_mem"));
      tbl.push_back(mk(0, T_OP,    0, 0, 0, 0, 0, 32'h0,   0, 0, 4'b0110, "flush_after_mem"));
      tbl.push_back(mk(0, T_OP,    0, 0, 0, 0, 0, 32'h0,   0, 0, 4'b0000, "idle4"));
      // redirect and load-use together: redirect wins
      tbl.push_back(mk(0, T_OP,    5, 7, 1, 5, 1, 32'h500, 0, 0, 4'b0111, "redir_beats_lu"));
      tbl.push_back(mk(0, T_OP,    5, 7, 1, 5, 0, 32'h0,   0, 0, 4'b0110, "flush_no_lu"));
      tbl.push_back(mk(0, T_OP,    0, 0, 0, 0, 0, 32'h0,   0, 0, 4'b0000, "idle5"));
      // wait inside the flush window: count frozen, flush resumes after ready
      tbl.push_back(mk(0, T_OP,    0, 0, 0, 0, 1, 32'h600, 0, 0, 4'b0111, "redir_0x600"));
      tbl.push_back(mk(0, T_OP,    0, 0, 0, 0, 0, 32'h0,   1, 0, 4'b1100, "wait_in_flush"));
      tbl.push_back(mk(0, T_OP,    0, 0, 0, 0, 0, 32'h0,   1, 1, 4'b0000, "ready_in_mem"));
      tbl.push_back(mk(0, T_OP,    0, 0, 0, 0, 0, 32'h0,   0, 0, 4'b0110, "flush_resumed"));
      tbl.push_back(mk(0, T_OP,    0, 0, 0, 0, 0, 32'h0,   0, 0, 4'b0000, "idle6"));
      // wait beats load-use, hazard raised again once back in S_RUN
      tbl.push_back(mk(0, T_OP,    5, 7, 1, 5, 0, 32'h0,   1, 0, 4'b1000, "wait_beats_lu"));
      tbl.push_back(mk(0, T_OP,    5, 7, 1, 5, 0, 32'h0,   1, 1, 4'b0000, "ready_lu_held"));
      tbl.push_back(mk(0, T_OP,    5, 7, 1, 5, 0, 32'h0,   0, 0, 4'b1010, "lu_after_mem"));
      tbl.push_back(mk(0, T_OP,    0, 0, 0, 0, 0, 32'h0,   0, 0, 4'b0000, "idle7"));
      tbl.push_back(mk(0, T_OP,    0, 0, 0, 0, 0, 32'h0,   1, 1, 4'b0000, "mem_no_wait"));

      drive(tbl[0]);
      exp_stalls = 0;
      exp_redirs = 0;
      foreach (tbl[i]) begin
         step(tbl[i]);
         if (!tbl[i].rst) begin
            exp_stalls += int'(tbl[i].exp[3]);
            exp_redirs += int'(tbl[i].exp[0]);
         end
      end

`ifdef TINY_RV_HAZARD_PERF_EN
      @(posedge clk);
      #1;
      drive(mk(0, T_OP, 0, 0, 0, 0, 0, 32'h0, 0, 0, 4'b0000, "perf_idle"));
      @(negedge clk);
      n_cmp++;
      if (o_stall_cycles !== 32'(exp_stalls) || o_flush_events !== 32'(exp_redirs)) begin
         n_bad++;
         $display("FAIL perf_counts: got stall=%0d flush=%0d, expected stall=%0d flush=%0d",
                  o_stall_cycles, o_flush_events, exp_stalls, exp_redirs);
      end
`endif

      // reset asserted in S_FLUSH with count 1
      step(mk(0, T_OP, 0, 0, 0, 0, 1, 32'h700, 0, 0, 4'b0111, "redir_0x700"));
      step(mk(1, T_OP, 5, 7, 1, 5, 1, 32'h700, 0, 0, 4'b0000, "reset_in_flush"));
      step(mk(0, T_OP, 0, 0, 0, 0, 0, 32'h0,   0, 0, 4'b0000, "after_reset_no_flush"));
`ifdef TINY_RV_HAZARD_PERF_EN
      n_cmp++;
      if (o_stall_cycles !== 32'd0 || o_flush_events !== 32'd0) begin
         n_bad++;
         $display("FAIL perf_reset: got stall=%0d flush=%0d, expected 0 and 0",
                  o_stall_cycles, o_flush_events);
      end
`endif
      // normal operation resumes after reset
      step(mk(0, T_OP, 5, 7, 1, 5, 0, 32'h0, 0, 0, 4'b1010, "lu_after_reset"));
      v = mk(0, T_OP, 0, 0, 0, 0, 1, 32'hABC, 0, 0, 4'b0111, "redir_after_reset");
      step(v);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
